// File: rtl/io_pkg.sv
// io_pkg: shared constants for the memory-mapped I/O unit.
//   NUM_IO_PORTS     number of input channels and of output ports
//   IO_ADDR_W        width of the cpu I/O address
//   IO_ADDR_PORT0..3 addresses of the four data ports
//   IO_ADDR_STATUS   address of the {full, nonempty} status word
//   is_port_addr()   true when an address selects one of the data ports
package io_pkg;

    localparam int NUM_IO_PORTS = 4;
    localparam int IO_ADDR_W    = 3;

    localparam logic [IO_ADDR_W-1:0] IO_ADDR_PORT0  = 3'd0;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_PORT1  = 3'd1;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_PORT2  = 3'd2;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_PORT3  = 3'd3;
    localparam logic [IO_ADDR_W-1:0] IO_ADDR_STATUS = 3'd4;

    function automatic logic is_port_addr(input logic [IO_ADDR_W-1:0] addr);
        return addr <= IO_ADDR_PORT3;
    endfunction

endpackage

// File: rtl/io_if.sv
// io_if: cpu-side I/O bus of the I/O unit.
//   we     cpu I/O write enable
//   re     cpu I/O read enable
//   addr   0-3 data port, 4 status, 5-7 unmapped
//   wdata  write data
//   rdata  read data, combinational from the unit
// Modports: master = cpu side, slave = I/O unit side.
interface io_if
    import io_pkg::*;
#(
    parameter int DATA_W = 8
);

    logic                 we;
    logic                 re;
    logic [IO_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    rdata;

    modport master (
        output we, re, addr, wdata,
        input  rdata
    );

    modport slave (
        input  we, re, addr, wdata,
        output rdata
    );

endinterface

// File: rtl/io_fifo.sv
// io_fifo: single-clock FIFO buffering one input channel.
//   clk, reset  clock and synchronous active-high reset
//   push, wdata write request and data; ignored while full
//   pop         read request; ignored while empty
//   head        word at the read pointer (valid only when !empty)
//   full, empty occupancy flags derived from the registered count
// A full FIFO refuses a push even if it is popped on the same edge, so the
// producer-side ready is pure registered state.
module io_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count==0 already makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: memory-mapped I/O unit behind the single-cycle cpu.
//   clk, reset  clock and synchronous active-high reset
//   cpu         io_if slave: we/re/addr/wdata in, combinational rdata out
//   in_data     channel n input word at [n*DATA_W +: DATA_W]
//   in_valid    channel n offers a word
//   in_ready    channel n FIFO not full
//   out_data    latched output port n at [n*DATA_W +: DATA_W]
//   out_strobe  one-cycle pulse after port n is written
// Reads of ports 0-3 return the FIFO head in the same cycle and pop it at
// the edge; address 4 returns {full, nonempty}; writes to 0-3 latch data.
module io_port_unit
    import io_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    io_if.slave                          cpu,
    input  logic [NUM_IO_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_IO_PORTS-1:0]        in_valid,
    output logic [NUM_IO_PORTS-1:0]        in_ready,
    output logic [NUM_IO_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_IO_PORTS-1:0]        out_strobe
);

    logic [DATA_W-1:0]       head [NUM_IO_PORTS];
    logic [NUM_IO_PORTS-1:0] full;
    logic [NUM_IO_PORTS-1:0] empty;
    logic [NUM_IO_PORTS-1:0] pop;
    logic [1:0]              sel;
    logic                    addr_is_port;

    assign sel          = cpu.addr[1:0];
    assign addr_is_port = is_port_addr(cpu.addr);
    assign in_ready     = ~full;

    // A read of an empty channel raises pop, but the FIFO ignores it.
    always_comb begin
        pop = '0;
        if (cpu.re && addr_is_port) pop[sel] = 1'b1;
    end

    for (genvar g = 0; g < NUM_IO_PORTS; g++) begin : g_fifo
        io_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .reset(reset),
            .push (in_valid[g]),
            .wdata(in_data[g*DATA_W +: DATA_W]),
            .pop  (pop[g]),
            .head (head[g]),
            .full (full[g]),
            .empty(empty[g])
        );
    end

    // NOTE: rdata gets a default first so every path assigns it and no latch forms.
    always_comb begin
        cpu.rdata = '0;
        if (cpu.re) begin
            if (addr_is_port) begin
                if (!empty[sel]) cpu.rdata = head[sel];
            end else if (cpu.addr == IO_ADDR_STATUS) begin
                cpu.rdata = DATA_W'({full, ~empty});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data   <= '0;
            out_strobe <= '0;
        end else begin
            out_strobe <= '0;
            if (cpu.we && addr_is_port) begin
                out_data[sel*DATA_W +: DATA_W] <= cpu.wdata;
                out_strobe[sel]                <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed self-checking bench for io_port_unit.
// Per-channel scoreboard queues receive words when they are offered and
// accepted; reads pop the expected head and compare it with cpu_rdata.
module tb_io_port_unit;
    import io_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_IO_PORTS*DW-1:0]  in_data;
    logic [NUM_IO_PORTS-1:0]     in_valid;
    logic [NUM_IO_PORTS-1:0]     in_ready;
    logic [NUM_IO_PORTS*DW-1:0]  out_data;
    logic [NUM_IO_PORTS-1:0]     out_strobe;

    io_if #(.DATA_W(DW)) cpu_bus ();

    io_port_unit #(
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_bus),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_strobe(out_strobe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb        [NUM_IO_PORTS][$];
    logic [DW-1:0] out_model [NUM_IO_PORTS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] status_model();
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < NUM_IO_PORTS; i++) begin
            s[4+i] = (sb[i].size() == DEPTH);
            s[i]   = (sb[i].size() != 0);
        end
        return 32'(s);
    endfunction

    function automatic logic [31:0] out_packed();
        logic [31:0] p;
        for (int i = 0; i < NUM_IO_PORTS; i++) p[i*DW +: DW] = out_model[i];
        return p;
    endfunction

    task automatic push_word(input int ch, input logic [DW-1:0] d);
        in_data[ch*DW +: DW] = d;
        in_valid[ch]         = 1'b1;
        if (sb[ch].size() < DEPTH) sb[ch].push_back(d);
        tick();
        in_valid[ch] = 1'b0;
    endtask

    task automatic read_port(input int ch, input string tag);
        logic [DW-1:0] exp;
        cpu_bus.re   = 1'b1;
        cpu_bus.addr = 3'(ch);
        #1;
        exp = (sb[ch].size() != 0) ? sb[ch].pop_front() : '0;
        check(tag, 32'(cpu_bus.rdata), 32'(exp));
        tick();
        cpu_bus.re = 1'b0;
    endtask

    task automatic read_status(input string tag);
        cpu_bus.re   = 1'b1;
        cpu_bus.addr = IO_ADDR_STATUS;
        #1;
        check(tag, 32'(cpu_bus.rdata), status_model());
        tick();
        cpu_bus.re = 1'b0;
    endtask

    task automatic write_port(input logic [2:0] addr, input logic [DW-1:0] d);
        cpu_bus.we    = 1'b1;
        cpu_bus.addr  = addr;
        cpu_bus.wdata = d;
        if (is_port_addr(addr)) out_model[addr[1:0]] = d;
        tick();
        cpu_bus.we = 1'b0;
    endtask

    initial begin
        cpu_bus.we    = 1'b0;
        cpu_bus.re    = 1'b0;
        cpu_bus.addr  = '0;
        cpu_bus.wdata = '0;
        for (int i = 0; i < NUM_IO_PORTS; i++) out_model[i] = '0;

        // 1: reset while every channel offers data
        reset    = 1'b1;
        in_valid = 4'hF;
        in_data  = '1;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 4'h0;
        check("rst_in_ready", 32'(in_ready), 32'hF);
        check("rst_out_data", out_data, 32'h0);
        check("rst_strobe", 32'(out_strobe), 32'h0);
        #1;
        check("rst_rdata_idle", 32'(cpu_bus.rdata), 32'h0);
        read_status("rst_status");

        // 2: single word on ch2, no bypass, then popped
        push_word(2, 8'hA5);
        read_port(2, "ch2_head");
        read_status("ch2_status_after_pop");

        // 3: fill ch0, reject fifth word, drain in order, read past empty
        push_word(0, 8'h11);
        push_word(0, 8'h22);
        push_word(0, 8'h33);
        push_word(0, 8'h44);
        check("ch0_full_ready", 32'(in_ready[0]), 32'h0);
        read_status("ch0_full_status");
        push_word(0, 8'h55);
        read_status("ch0_status_after_reject");
        for (int i = 0; i < DEPTH; i++) read_port(0, "ch0_drain");
        read_port(0, "ch0_empty_read");
        read_status("ch0_status_drained");

        // 4: simultaneous push and pop on ch1 holding one word
        push_word(1, 8'h1A);
        in_data[1*DW +: DW] = 8'h3C;
        in_valid[1]         = 1'b1;
        cpu_bus.re          = 1'b1;
        cpu_bus.addr        = IO_ADDR_PORT1;
        #1;
        check("ch1_pushpop_head", 32'(cpu_bus.rdata), 32'(sb[1].pop_front()));
        sb[1].push_back(8'h3C);
        tick();
        in_valid[1] = 1'b0;
        cpu_bus.re  = 1'b0;
        read_status("ch1_count_one");
        read_port(1, "ch1_second_word");

        // 5: output port writes, strobes and unmapped addresses
        write_port(IO_ADDR_PORT3, 8'h7E);
        check("wr3_data", out_data, out_packed());
        check("wr3_strobe", 32'(out_strobe), 32'h8);
        tick();
        check("wr3_strobe_gone", 32'(out_strobe), 32'h0);
        write_port(3'd6, 8'h99);
        check("wr6_strobe", 32'(out_strobe), 32'h0);
        check("wr6_data", out_data, out_packed());
        cpu_bus.re   = 1'b1;
        cpu_bus.addr = 3'd6;
        #1;
        check("rd6_zero", 32'(cpu_bus.rdata), 32'h0);
        cpu_bus.re = 1'b0;
        cpu_bus.we    = 1'b1;
        cpu_bus.addr  = IO_ADDR_PORT0;
        cpu_bus.wdata = 8'hC1;
        out_model[0]  = 8'hC1;
        tick();
        check("b2b_strobe0", 32'(out_strobe), 32'h1);
        cpu_bus.addr  = IO_ADDR_PORT1;
        cpu_bus.wdata = 8'hD2;
        out_model[1]  = 8'hD2;
        tick();
        cpu_bus.we = 1'b0;
        check("b2b_strobe1", 32'(out_strobe), 32'h2);
        check("b2b_data", out_data, out_packed());

        // 6: reset mid-transfer discards buffered words and outputs
        push_word(0, 8'h61);
        push_word(0, 8'h62);
        push_word(0, 8'h63);
        read_status("ch0_three_status");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_IO_PORTS; i++) begin
            sb[i].delete();
            out_model[i] = '0;
        end
        check("rst2_in_ready", 32'(in_ready), 32'hF);
        check("rst2_out_data", out_data, out_packed());
        read_status("rst2_status");
        read_port(0, "rst2_ch0_unreadable");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
